// File: rtl/demux_2to4_l1_if.sv
// Byte-lane bundle between the L1 receive path and the 2-to-4 demultiplexer.
// The master side drives the two incoming byte lanes.
// The slave side (the demux) drives the four output lanes and the drop flags.
interface demux_2to4_l1_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in1;
  logic              valid_in1;
  logic [DATA_W-1:0] data_in2;
  logic              valid_in2;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic [DATA_W-1:0] data_out3;
  logic              valid_out0;
  logic              valid_out1;
  logic              valid_out2;
  logic              valid_out3;
  logic              drop_err1;
  logic              drop_err2;

  modport master (
    output data_in1, valid_in1, data_in2, valid_in2,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  drop_err1, drop_err2
  );

  modport slave (
    input  data_in1, valid_in1, data_in2, valid_in2,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output drop_err1, drop_err2
  );
endinterface

// File: rtl/demux_2to4_l1.sv
// L1 2-to-4 byte demultiplexer (receive-side inverse of the 4-to-2 mux).
// Each input lane pairs successive valid bytes: the first byte goes to the
// even output, the second byte to the odd output. The two lanes are independent.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_EMPTY | no byte held; the next valid byte starts a pair
//  ST_HALF  | first byte held; waiting for the second one (gap-limited)
module demux_2to4_l1 #(
  parameter int DATA_W  = 8,
  parameter int GAP_MAX = 4
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  demux_2to4_l1_if.slave   bus
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  // The pair stays valid for one clk_f period (two clk_2f cycles). The timer
  // holds the number of extra cycles left after the completion cycle.
  localparam int VALID_HOLD = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } lane_state_e;

  logic [DATA_W-1:0] lane_din    [2];
  logic              lane_vin    [2];
  logic [DATA_W-1:0] lane_first  [2];
  logic [DATA_W-1:0] lane_second [2];
  logic              lane_valid  [2];
  logic              lane_drop   [2];

  assign lane_din[0] = bus.data_in1;
  assign lane_vin[0] = bus.valid_in1;
  assign lane_din[1] = bus.data_in2;
  assign lane_vin[1] = bus.valid_in2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    lane_state_e       state_q;
    logic [DATA_W-1:0] hold_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              valid_tmr_q;
    logic [DATA_W-1:0] first_q;
    logic [DATA_W-1:0] second_q;
    logic              valid_q;
    logic              drop_q;

    // Per-lane pairing FSM with registered outputs, gap timeout and valid timer.
    always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
        state_q     <= ST_EMPTY;
        hold_q      <= '0;
        gap_cnt_q   <= '0;
        valid_tmr_q <= 1'b0;
        first_q     <= '0;
        second_q    <= '0;
        valid_q     <= 1'b0;
        drop_q      <= 1'b0;
      end else begin
        drop_q <= 1'b0;

        // Valid timer runs down; a completion below overrides it (restart).
        if (valid_q) begin
          if (valid_tmr_q == 1'b0) begin
            valid_q <= 1'b0;
          end else begin
            valid_tmr_q <= valid_tmr_q - 1'b1;
          end
        end

        case (state_q)
          ST_EMPTY: begin
            if (lane_vin[g]) begin
              hold_q    <= lane_din[g];
              gap_cnt_q <= '0;
              state_q   <= ST_HALF;
            end
          end
          ST_HALF: begin
            if (lane_vin[g]) begin
              first_q     <= hold_q;
              second_q    <= lane_din[g];
              valid_q     <= 1'b1;
              valid_tmr_q <= 1'(VALID_HOLD - 1);
              hold_q      <= '0;
              gap_cnt_q   <= '0;
              state_q     <= ST_EMPTY;
            end else if (gap_cnt_q == GAP_W'(GAP_MAX - 1)) begin
              // Partner byte never came: discard the held half and flag it.
              hold_q    <= '0;
              gap_cnt_q <= '0;
              drop_q    <= 1'b1;
              state_q   <= ST_EMPTY;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end

    assign lane_first[g]  = first_q;
    assign lane_second[g] = second_q;
    assign lane_valid[g]  = valid_q;
    assign lane_drop[g]   = drop_q;
  end

  assign bus.data_out0  = lane_first[0];
  assign bus.data_out1  = lane_second[0];
  assign bus.data_out2  = lane_first[1];
  assign bus.data_out3  = lane_second[1];
  assign bus.valid_out0 = lane_valid[0];
  assign bus.valid_out1 = lane_valid[0];
  assign bus.valid_out2 = lane_valid[1];
  assign bus.valid_out3 = lane_valid[1];
  assign bus.drop_err1  = lane_drop[0];
  assign bus.drop_err2  = lane_drop[1];

endmodule
